// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around a single-port synchronous SRAM with one output register.
// Latency: a word pushed into an empty FIFO is visible on out_valid three cycles later.
// Backpressure: in_ready drops when the SRAM is full or a read owns the port this cycle; out_ready stalls reads.
module sram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int BIT_WIDTH  = 8
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_WIDTH-1:0]  out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  mem_ena,
    output logic                  mem_wea,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0]  mem_din,
    input  logic [BIT_WIDTH-1:0]  mem_dout
);

    localparam int                    DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  rd_pend;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BIT_WIDTH-1:0]  din_q;
    logic                  rd_go;
    logic                  wr_go;

    // Port arbitration: a read wins whenever the output stage can take its result.
    always_comb begin
        rd_go    = (mem_count != '0) && !rd_pend && (!out_valid || out_ready);
        in_ready = (mem_count != DEPTH_W) && !rd_go;
        wr_go    = in_valid && in_ready;
        mem_ena  = rd_go || wr_go;
        mem_wea  = wr_go;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (rd_go) begin
            mem_addr = rd_ptr;
        end else if (wr_go) begin
            mem_addr = wr_ptr;
            mem_din  = in_data;
        end
    end

    // Occupancy flags; rd_pend and out_valid are never both set, so count tops out at DEPTH+1.
    always_comb begin
        count = mem_count + {{ADDR_WIDTH{1'b0}}, rd_pend} + {{ADDR_WIDTH{1'b0}}, out_valid};
        full  = (mem_count == DEPTH_W);
        empty = (count == '0);
    end

    // Pointer, occupancy and output-register updates; an in-flight read is dropped on reset.
    always_ff @(posedge clka) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            addr_q  <= mem_addr;
            din_q   <= mem_din;
            rd_pend <= rd_go;
            if (rd_go) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                mem_count <= mem_count - CNT_ONE;
            end else if (wr_go) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                mem_count <= mem_count + CNT_ONE;
            end
            if (rd_pend) begin
                out_data  <= mem_dout;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural SRAM and a cycle-level reference.
// Directed scenarios plus constrained-random back-pressure.
// Expected values are hand-derived constants or come from the reference queue.
module tb_sram_fifo_ctrl;

    logic       clka = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       mem_ena;
    logic       mem_wea;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    always #5 clka = ~clka;

    sram_fifo_ctrl #(.ADDR_WIDTH(4), .BIT_WIDTH(8)) dut (
        .clka(clka), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Single-port SRAM with registered read data.
    logic [7:0] sram [16];
    always @(posedge clka) begin
        if (mem_ena) begin
            if (mem_wea) sram[mem_addr] <= mem_din;
            else         mem_dout <= sram[mem_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference state
    logic [7:0] q[$];
    int         m_cnt;
    bit         m_pend;
    bit         m_ov;
    logic [3:0] wp;
    logic [3:0] rp;
    bit         last_wr;
    int         cyc_n = 0;
    logic [7:0] pop_dat[$];
    int         pop_cyc[$];
    logic [7:0] sent[$];

    // One clock cycle: compare outputs against the reference, then advance it past the edge.
    task automatic cyc();
        bit rg, ir, wr, pp;
        logic [7:0] d;
        #2;
        rg = (m_cnt != 0) && !m_pend && (!m_ov || out_ready);
        ir = (m_cnt != 16) && !rg;
        wr = in_valid && ir;
        pp = m_ov && out_ready;
        d  = in_data;
        chk("in_ready", 32'(in_ready), 32'(ir));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) chk("out_data", 32'(out_data), 32'(q[0]));
        chk("count", 32'(count), 32'(m_cnt + int'(m_pend) + int'(m_ov)));
        chk("full", 32'(full), 32'(m_cnt == 16));
        chk("empty", 32'(empty), 32'((m_cnt + int'(m_pend) + int'(m_ov)) == 0));
        chk("mem_ena", 32'(mem_ena), 32'(rg || wr));
        chk("mem_wea", 32'(mem_wea), 32'(wr));
        if (rg) chk("rd_addr", 32'(mem_addr), 32'(rp));
        else if (wr) begin
            chk("wr_addr", 32'(mem_addr), 32'(wp));
            chk("wr_din", 32'(mem_din), 32'(d));
        end
        last_wr = wr;
        if (pp) begin
            pop_dat.push_back(out_data);
            pop_cyc.push_back(cyc_n);
        end
        @(posedge clka);
        #1;
        if (pp) void'(q.pop_front());
        if (wr) q.push_back(d);
        m_cnt  = m_cnt + int'(wr) - int'(rg);
        m_ov   = m_pend ? 1'b1 : (pp ? 1'b0 : m_ov);
        m_pend = rg;
        if (rg) rp = rp + 4'd1;
        if (wr) wp = wp + 4'd1;
        cyc_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clka);
        #1;
        rst = 1'b0;
        q.delete();
        m_cnt = 0; m_pend = 0; m_ov = 0; wp = '0; rp = '0;
    endtask

    // Hold in_valid with the given word until it is accepted (bounded).
    task automatic push(input logic [7:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        do begin
            cyc();
            t++;
        end while (!last_wr && t < 20);
        chk("push_acc", 32'(last_wr), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        do_reset();
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        // Single word latency
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        #1;
        chk("c0_ena", 32'(mem_ena), 32'd1);
        chk("c0_wea", 32'(mem_wea), 32'd1);
        chk("c0_addr", 32'(mem_addr), 32'd0);
        chk("c0_din", 32'(mem_din), 32'hA5);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("c1_ena", 32'(mem_ena), 32'd1);
        chk("c1_wea", 32'(mem_wea), 32'd0);
        chk("c1_addr", 32'(mem_addr), 32'd0);
        chk("c1_in_ready", 32'(in_ready), 32'd0);
        cyc();
        cyc();
        #1;
        chk("c3_out_valid", 32'(out_valid), 32'd1);
        chk("c3_out_data", 32'(out_data), 32'hA5);
        chk("c3_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        #1;
        chk("pop_count", 32'(count), 32'd0);
        chk("pop_empty", 32'(empty), 32'd1);

        // Fill to capacity with the output stalled
        for (int k = 0; k < 17; k++) push(8'(k));
        in_valid = 1'b1; in_data = 8'h11;
        #1;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd17);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_wea", 32'(mem_wea), 32'd0);
        chk("fill_head", 32'(out_data), 32'h00);
        repeat (3) cyc();
        in_valid = 1'b0;

        // Drain: one word every two cycles, in order
        pop_dat.delete(); pop_cyc.delete();
        out_ready = 1'b1;
        t = 0;
        while (pop_dat.size() < 17 && t < 100) begin cyc(); t++; end
        chk("drain_n", 32'(pop_dat.size()), 32'd17);
        foreach (pop_dat[i]) chk("drain_dat", 32'(pop_dat[i]), 32'(i));
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("drain_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
        #1;
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);

        // Continuous stream of 40 words, pointers wrap twice
        pop_dat.delete(); pop_cyc.delete();
        n = 0; t = 0;
        while ((n < 40 || pop_dat.size() < 40) && t < 400) begin
            in_valid = (n < 40);
            in_data  = 8'(n);
            cyc();
            if (last_wr) n++;
            t++;
        end
        in_valid = 1'b0;
        chk("stream_n", 32'(pop_dat.size()), 32'd40);
        foreach (pop_dat[i]) chk("stream_dat", 32'(pop_dat[i]), 32'(i));

        // Random back-pressure, 200 words
        pop_dat.delete(); pop_cyc.delete(); sent.delete();
        n = 0; t = 0;
        while ((n < 200 || pop_dat.size() < 200) && t < 4000) begin
            in_valid  = (n < 200) && ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
            if (last_wr) begin sent.push_back(in_data); n++; end
            t++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("rand_n", 32'(pop_dat.size()), 32'd200);
        foreach (pop_dat[i]) if (i < sent.size()) chk("rand_dat", 32'(pop_dat[i]), 32'(sent[i]));

        // Reset while a read is in flight
        push(8'h77);
        in_valid = 1'b0;
        cyc();
        #1;
        chk("pend_count", 32'(count), 32'd1);
        do_reset();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        in_valid = 1'b1; in_data = 8'h3C;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'h3C);
        chk("post_rst_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        repeat (3) cyc();
        chk("sole_empty", 32'(empty), 32'd1);
        chk("sole_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
